// File: rtl/axis_demux.sv
// AXI-Stream 1:2 packet demultiplexer.
// A select word picks the destination port, then one packet is forwarded
// through a single output register to that port. Each port keeps a
// wrapping count of packets fully delivered.
module axis_demux #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,

   // destination select stream
   input  logic                  sel_tdata,
   input  logic                  sel_tvalid,
   output logic                  sel_tready,

   // input packet stream
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,

   // output port 0
   output logic [DATA_WIDTH-1:0] m0_tdata,
   output logic                  m0_tvalid,
   output logic                  m0_tlast,
   input  logic                  m0_tready,

   // output port 1
   output logic [DATA_WIDTH-1:0] m1_tdata,
   output logic                  m1_tvalid,
   output logic                  m1_tlast,
   input  logic                  m1_tready,

   // delivered packet counters
   output logic [CNT_WIDTH-1:0]  pkt_cnt_0,
   output logic [CNT_WIDTH-1:0]  pkt_cnt_1
);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StRoute = 1'b1;

   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

   // FSM and the destination latched from the select word
   logic [0:0]            state_q, state_d;
   logic                  route_dest_q, route_dest_d;

   // single output register {data, last, dest} plus its valid flag
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic                  out_dest_q, out_dest_d;

   logic [CNT_WIDTH-1:0]  pkt_cnt_0_q, pkt_cnt_0_d;
   logic [CNT_WIDTH-1:0]  pkt_cnt_1_q, pkt_cnt_1_d;

   logic                  out_ready;
   logic                  out_hs;
   logic                  sel_hs;
   logic                  beat_accept;

   // Handshake decode. The register's own dest steers the drain, so a last
   // beat can still leave while the next select word is being taken.
   always_comb begin
      out_ready   = out_dest_q ? m1_tready : m0_tready;
      out_hs      = out_valid_q && out_ready;
      sel_tready  = reset_n && (state_q == StIdle);
      s_tready    = reset_n && (state_q == StRoute) && (!out_valid_q || out_ready);
      sel_hs      = sel_tvalid && sel_tready;
      beat_accept = s_tvalid && s_tready;
   end

   // FSM next state: IDLE waits for a select word, ROUTE runs until tlast
   always_comb begin
      state_d      = state_q;
      route_dest_d = route_dest_q;
      case (state_q)
         StIdle: begin
            if (sel_hs) begin
               state_d      = StRoute;
               route_dest_d = sel_tdata;
            end
         end
         StRoute: begin
            if (beat_accept && s_tlast) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output register: load on accept, otherwise clear valid once drained
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_dest_d  = out_dest_q;
      if (beat_accept) begin
         out_valid_d = 1'b1;
         out_data_d  = s_tdata;
         out_last_d  = s_tlast;
         out_dest_d  = route_dest_q;
      end else if (out_hs) begin
         out_valid_d = 1'b0;
      end
   end

   // Packet counters advance on the handshake of each last beat
   always_comb begin
      pkt_cnt_0_d = pkt_cnt_0_q;
      pkt_cnt_1_d = pkt_cnt_1_q;
      if (out_hs && out_last_q) begin
         if (out_dest_q) begin
            pkt_cnt_1_d = pkt_cnt_1_q + CntOne;
         end else begin
            pkt_cnt_0_d = pkt_cnt_0_q + CntOne;
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         route_dest_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         out_dest_q   <= 1'b0;
         pkt_cnt_0_q  <= '0;
         pkt_cnt_1_q  <= '0;
      end else begin
         state_q      <= state_d;
         route_dest_q <= route_dest_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         out_dest_q   <= out_dest_d;
         pkt_cnt_0_q  <= pkt_cnt_0_d;
         pkt_cnt_1_q  <= pkt_cnt_1_d;
      end
   end

   // Port outputs: only the register's destination sees valid/last
   always_comb begin
      m0_tdata  = out_data_q;
      m1_tdata  = out_data_q;
      m0_tvalid = out_valid_q && !out_dest_q;
      m1_tvalid = out_valid_q && out_dest_q;
      m0_tlast  = out_valid_q && !out_dest_q && out_last_q;
      m1_tlast  = out_valid_q && out_dest_q && out_last_q;
      pkt_cnt_0 = pkt_cnt_0_q;
      pkt_cnt_1 = pkt_cnt_1_q;
   end

endmodule

// File: tb/tb_axis_demux.sv
// Directed bench for axis_demux: a per-cycle vector table for routing
// and back-to-back packets, plus hand sequences for stall, reset and wrap.
module tb_axis_demux;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          sel_tdata, sel_tvalid, sel_tready;
   logic [DW-1:0] s_tdata;
   logic          s_tvalid, s_tlast, s_tready;
   logic [DW-1:0] m0_tdata, m1_tdata;
   logic          m0_tvalid, m0_tlast, m0_tready;
   logic          m1_tvalid, m1_tlast, m1_tready;
   logic [CW-1:0] pkt_cnt_0, pkt_cnt_1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axis_demux #(
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sel_tdata  (sel_tdata),
      .sel_tvalid (sel_tvalid),
      .sel_tready (sel_tready),
      .s_tdata    (s_tdata),
      .s_tvalid   (s_tvalid),
      .s_tlast    (s_tlast),
      .s_tready   (s_tready),
      .m0_tdata   (m0_tdata),
      .m0_tvalid  (m0_tvalid),
      .m0_tlast   (m0_tlast),
      .m0_tready  (m0_tready),
      .m1_tdata   (m1_tdata),
      .m1_tvalid  (m1_tvalid),
      .m1_tlast   (m1_tlast),
      .m1_tready  (m1_tready),
      .pkt_cnt_0  (pkt_cnt_0),
      .pkt_cnt_1  (pkt_cnt_1)
   );

   typedef struct packed {
      logic          sel_v;
      logic          sel_d;
      logic          s_v;
      logic [DW-1:0] s_d;
      logic          s_l;
      logic          m0_r;
      logic          m1_r;
      logic          e_sel_r;
      logic          e_s_r;
      logic          e_m0_v;
      logic          e_m1_v;
      logic [DW-1:0] e_d;
      logic          e_l;
      logic [CW-1:0] e_c0;
      logic [CW-1:0] e_c1;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic sv, input logic sd, input logic bv, input logic [DW-1:0] bd,
                        input logic bl, input logic r0, input logic r1);
      sel_tvalid = sv;
      sel_tdata  = sd;
      s_tvalid   = bv;
      s_tdata    = bd;
      s_tlast    = bl;
      m0_tready  = r0;
      m1_tready  = r1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(0, 0, 0, 8'h00, 0, 1, 1);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // sel word then a single-beat packet; the beat drains during the next cycle
   task automatic send_one(input logic dest, input logic [DW-1:0] d);
      drive(1, dest, 0, 8'h00, 0, 1, 1);
      tick();
      drive(0, 0, 1, d, 1, 1, 1);
      tick();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //          sv sd bv  bd    bl r0 r1 | esr esr em0 em1 ed    el c0 c1
      vecs[0]  = '{0, 0, 1, 8'h55, 0, 1, 1,  1,  0,  0,  0, 8'h00, 0, 0, 0};
      vecs[1]  = '{0, 0, 1, 8'h55, 0, 1, 1,  1,  0,  0,  0, 8'h00, 0, 0, 0};
      vecs[2]  = '{1, 1, 0, 8'h00, 0, 1, 1,  1,  0,  0,  0, 8'h00, 0, 0, 0};
      vecs[3]  = '{0, 0, 1, 8'h11, 0, 0, 1,  0,  1,  0,  0, 8'h00, 0, 0, 0};
      vecs[4]  = '{0, 0, 1, 8'h22, 0, 0, 1,  0,  1,  0,  1, 8'h11, 0, 0, 0};
      vecs[5]  = '{0, 0, 1, 8'h33, 1, 0, 1,  0,  1,  0,  1, 8'h22, 0, 0, 0};
      vecs[6]  = '{1, 0, 0, 8'h00, 0, 1, 1,  1,  0,  0,  1, 8'h33, 1, 0, 0};
      vecs[7]  = '{0, 0, 1, 8'hA1, 1, 1, 0,  0,  1,  0,  0, 8'h00, 0, 0, 1};
      vecs[8]  = '{1, 1, 0, 8'h00, 0, 1, 0,  1,  0,  1,  0, 8'hA1, 1, 0, 1};
      vecs[9]  = '{0, 0, 1, 8'hB2, 1, 0, 1,  0,  1,  0,  0, 8'h00, 0, 1, 1};
      vecs[10] = '{0, 0, 0, 8'h00, 0, 0, 1,  1,  0,  0,  1, 8'hB2, 1, 1, 1};
      vecs[11] = '{0, 0, 0, 8'h00, 0, 0, 0,  1,  0,  0,  0, 8'h00, 0, 1, 2};

      // reset state
      do_reset();
      chk("rst_m0_tvalid", m0_tvalid, 0);
      chk("rst_m1_tvalid", m1_tvalid, 0);
      chk("rst_m0_tdata", m0_tdata, 0);
      chk("rst_pkt_cnt_0", pkt_cnt_0, 0);
      chk("rst_pkt_cnt_1", pkt_cnt_1, 0);

      // early beats stalled, 3-beat packet to port 1, back-to-back 1-beat packets
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].sel_v, vecs[i].sel_d, vecs[i].s_v, vecs[i].s_d, vecs[i].s_l,
               vecs[i].m0_r, vecs[i].m1_r);
         #1;
         chk($sformatf("v%0d_sel_tready", i), sel_tready, vecs[i].e_sel_r);
         chk($sformatf("v%0d_s_tready", i), s_tready, vecs[i].e_s_r);
         chk($sformatf("v%0d_m0_tvalid", i), m0_tvalid, vecs[i].e_m0_v);
         chk($sformatf("v%0d_m1_tvalid", i), m1_tvalid, vecs[i].e_m1_v);
         if (vecs[i].e_m0_v) begin
            chk($sformatf("v%0d_m0_tdata", i), m0_tdata, vecs[i].e_d);
            chk($sformatf("v%0d_m0_tlast", i), m0_tlast, vecs[i].e_l);
         end else begin
            chk($sformatf("v%0d_m0_tlast_idle", i), m0_tlast, 0);
         end
         if (vecs[i].e_m1_v) begin
            chk($sformatf("v%0d_m1_tdata", i), m1_tdata, vecs[i].e_d);
            chk($sformatf("v%0d_m1_tlast", i), m1_tlast, vecs[i].e_l);
         end else begin
            chk($sformatf("v%0d_m1_tlast_idle", i), m1_tlast, 0);
         end
         chk($sformatf("v%0d_pkt_cnt_0", i), pkt_cnt_0, vecs[i].e_c0);
         chk($sformatf("v%0d_pkt_cnt_1", i), pkt_cnt_1, vecs[i].e_c1);
         tick();
      end

      // downstream stall on port 0 while beat 2 sits in the output register
      do_reset();
      drive(1, 0, 0, 8'h00, 0, 1, 1);
      tick();
      drive(0, 0, 1, 8'h01, 0, 1, 1);
      #1;
      chk("stall_b1_s_tready", s_tready, 1);
      tick();
      drive(0, 0, 1, 8'h02, 0, 1, 1);
      #1;
      chk("stall_b1_out", m0_tdata, 8'h01);
      chk("stall_b1_valid", m0_tvalid, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 8'h03, 1, 0, 1);
         #1;
         chk($sformatf("stall%0d_s_tready", i), s_tready, 0);
         chk($sformatf("stall%0d_m0_tvalid", i), m0_tvalid, 1);
         chk($sformatf("stall%0d_m0_tdata", i), m0_tdata, 8'h02);
         chk($sformatf("stall%0d_m1_tvalid", i), m1_tvalid, 0);
         tick();
      end
      drive(0, 0, 1, 8'h03, 1, 1, 1);
      #1;
      chk("stall_rel_s_tready", s_tready, 1);
      chk("stall_rel_m0_tdata", m0_tdata, 8'h02);
      tick();
      drive(0, 0, 0, 8'h00, 0, 1, 1);
      #1;
      chk("stall_b3_m0_tdata", m0_tdata, 8'h03);
      chk("stall_b3_m0_tlast", m0_tlast, 1);
      chk("stall_b3_sel_tready", sel_tready, 1);
      tick();
      chk("stall_drained", m0_tvalid, 0);
      chk("stall_pkt_cnt_0", pkt_cnt_0, 1);

      // reset in the middle of a 4-beat packet
      do_reset();
      drive(1, 0, 0, 8'h00, 0, 1, 1);
      tick();
      drive(0, 0, 1, 8'h10, 0, 1, 1);
      tick();
      reset_n = 1'b0;
      drive(0, 0, 1, 8'h20, 0, 1, 1);
      #1;
      chk("mid_rst_s_tready", s_tready, 0);
      chk("mid_rst_sel_tready", sel_tready, 0);
      tick();
      chk("mid_rst_m0_tvalid", m0_tvalid, 0);
      chk("mid_rst_m0_tdata", m0_tdata, 0);
      chk("mid_rst_m0_tlast", m0_tlast, 0);
      chk("mid_rst_m1_tvalid", m1_tvalid, 0);
      chk("mid_rst_pkt_cnt_0", pkt_cnt_0, 0);
      reset_n = 1'b1;
      drive(0, 0, 1, 8'h30, 0, 1, 1);
      #1;
      chk("post_rst_sel_tready", sel_tready, 1);
      chk("post_rst_s_tready", s_tready, 0);
      send_one(0, 8'hAA);
      drive(0, 0, 0, 8'h00, 0, 1, 1);
      #1;
      chk("post_rst_m0_tvalid", m0_tvalid, 1);
      chk("post_rst_m0_tdata", m0_tdata, 8'hAA);
      tick();
      chk("post_rst_pkt_cnt_0", pkt_cnt_0, 1);

      // 2-bit counter wraps after four packets
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send_one(0, 8'(8'h40 + i));
      end
      drive(0, 0, 0, 8'h00, 0, 1, 1);
      tick();
      chk("wrap_pkt_cnt_0", pkt_cnt_0, 1);
      chk("wrap_pkt_cnt_1", pkt_cnt_1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_demux.md
AXIS_DEMUX -- requirements
Module: axis_demux

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the tdata width of the input stream and both output streams.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, meaning the width of each per-port packet counter.
REQ-003 The block SHALL use reset reset_n, synchronous, active-low, and clock clk.
REQ-004 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 sel_tdata  input  1  destination select: 0 = port 0, 1 = port 1.
REQ-007 sel_tvalid  input  1  select word valid.
REQ-008 sel_tready  output  1  select word accepted when high together with sel_tvalid.
REQ-009 s_tdata  input  DATA_WIDTH  input stream data.
REQ-010 s_tvalid  input  1  input beat valid.
REQ-011 s_tlast  input  1  input beat is the last beat of its packet.
REQ-012 s_tready  output  1  input beat accepted when high together with s_tvalid.
REQ-013 m0_tdata / m1_tdata  output  DATA_WIDTH  output stream data for port 0 / port 1.
REQ-014 m0_tvalid / m1_tvalid  output  1  output beat valid for port 0 / port 1.
REQ-015 m0_tlast / m1_tlast  output  1  output packet boundary for port 0 / port 1.
REQ-016 m0_tready / m1_tready  input  1  downstream ready for port 0 / port 1.
REQ-017 pkt_cnt_0 / pkt_cnt_1  output  CNT_WIDTH  count of packets fully delivered on port 0 / port 1.

Function
REQ-018 The block SHALL contain a two-state FSM: IDLE (awaiting a select word) and ROUTE (forwarding a packet).
REQ-019 In IDLE, sel_tready SHALL be 1 and s_tready SHALL be 0.
REQ-020 In IDLE, on sel_tvalid && sel_tready, the block SHALL latch sel_tdata into the destination register and enter ROUTE on the next cycle.
REQ-021 In ROUTE, sel_tready SHALL be 0, and the destination SHALL stay fixed for the whole packet.
REQ-022 In ROUTE, s_tready SHALL equal !out_valid || out_ready, where out_ready is the m*_tready of the port held in the output register.
REQ-023 An input beat SHALL be accepted when s_tvalid && s_tready; it SHALL be loaded into a single output register holding {data, last, dest} and SHALL appear at the outputs exactly 1 cycle later.
REQ-024 Acceptance of a beat with s_tlast = 1 SHALL return the FSM to IDLE on the next cycle.
REQ-025 The next select word MAY be accepted while that last beat is still in the output register; the register's own dest field SHALL steer it.
REQ-026 m0_tvalid SHALL be out_valid && dest == 0, and m1_tvalid SHALL be out_valid && dest == 1.
REQ-027 The non-selected port SHALL drive tvalid = 0 and tlast = 0; m*_tdata on that port is don't-care.
REQ-028 The output register SHALL hold its contents stable while out_valid && !out_ready; no beat SHALL be dropped or duplicated.
REQ-029 out_valid SHALL clear after an output handshake unless a new beat is accepted in the same cycle.
REQ-030 Sustained throughput SHALL be 1 beat per cycle while the selected downstream port holds tready high.
REQ-031 pkt_cnt_N SHALL increment by 1 on each handshake on port N with tlast = 1.
REQ-032 pkt_cnt_N SHALL wrap from 2^CNT_WIDTH-1 to 0.
REQ-033 The tready of the port that is not selected SHALL have no effect on block behaviour.
REQ-034 Input beats offered in IDLE SHALL be stalled (not accepted) until a select word is accepted.

Reset
REQ-035 While reset_n = 0 at a clock edge, the block SHALL set FSM = IDLE, dest = 0, out_valid = 0, pkt_cnt_0 = pkt_cnt_1 = 0, and all m*_tvalid, m*_tlast, and m*_tdata to 0.
REQ-036 sel_tready and s_tready SHALL be 0 while reset_n = 0.
REQ-037 Reset asserted mid-packet SHALL discard the partial packet and the output register contents; after release, the block SHALL wait in IDLE for a new select word.

Verification
REQ-038 Select 1, then a 3-beat packet 0x11, 0x22, 0x33 (last on 0x33), m1_tready = 1 -> m1 carries the beats on consecutive cycles starting 1 cycle after the first accept, m0_tvalid stays 0, pkt_cnt_1 = 1.
REQ-039 Select 0 with m0_tready held 0 for 4 cycles during beat 2 of a packet -> s_tready = 0 during the stall, m0_tdata is stable, and no beat is lost or repeated.
REQ-040 Beats offered before any select word -> s_tready = 0 and no m*_tvalid until sel_tvalid is accepted.
REQ-041 Back-to-back packets: select 0 with a 1-beat packet, then select 1 with a 1-beat packet -> each beat appears only on its own port and both counters equal 1.
REQ-042 reset_n = 0 asserted after beat 1 of a 4-beat packet -> all outputs are 0 next cycle; after release, a new select 0 with 1-beat 0xAA gives m0 = 0xAA and pkt_cnt_0 = 1.
REQ-043 With CNT_WIDTH = 2, send 5 packets to port 0 -> pkt_cnt_0 = 1 (wrap).
